// File: rtl/dmem_pkg.sv
// Shared constants for the data-bus responder: MMIO register map and STATUS layout.
package dmem_pkg;

  localparam logic [31:0] MMIO_BASE_DEF = 32'h8000_0000;

  localparam logic [7:0] CYCLE_OFS  = 8'h00;
  localparam logic [7:0] TXDATA_OFS = 8'h04;
  localparam logic [7:0] STATUS_OFS = 8'h08;

  localparam int unsigned ST_EMPTY_BIT = 0;
  localparam int unsigned ST_FULL_BIT  = 1;
  localparam int unsigned ST_OVF_BIT   = 2;
  localparam int unsigned ST_COUNT_LSB = 8;
  localparam int unsigned ST_COUNT_W   = 8;

endpackage

// File: rtl/dmem_responder_fifo.sv
// Synchronous FIFO with a registered head word and valid flag.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     head_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             push_ok, pop_ok;
  logic [CW-1:0]    remain;

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign head_data  = head_q;
  assign head_valid = valid_q;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted alongside a pop.
  always_comb begin
    pop_ok   = pop && valid_q;
    push_ok  = push && (!full || pop_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    remain   = count_q - CW'(pop_ok);
    count_d  = remain + CW'(push_ok);
    valid_d  = (count_d != '0);
    head_d   = head_q;
    if (remain != '0) begin
      head_d = mem_q[rd_ptr_d];
    end else if (push_ok) begin
      head_d = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  // Storage is not reset; only pointers define occupancy.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-bus responder: byte-lane RAM plus MMIO cycle counter and console TX FIFO.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready
);

  localparam int unsigned RAM_AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       ram_q [DEPTH_WORDS];
  logic [31:0]       cycle_q, cycle_d;
  logic              ovf_q, ovf_d;

  logic              is_mmio;
  logic [7:0]        ofs;
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_we;
  logic              cyc_wr;
  logic              tx_push;
  logic              st_clr;
  logic              con_pop;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [31:0]       status_word;
  logic              unused_bits;

  assign is_mmio = daddr[31];
  assign ofs     = daddr[7:0] - MMIO_BASE[7:0];
  assign ram_idx = daddr[RAM_AW+1:2];
  assign con_pop = con_valid && con_ready;
  assign unused_bits = ^{daddr[30:8], daddr[1:0]};

  // Write strobes decoded from the current bus request.
  always_comb begin
    ram_we  = !is_mmio;
    cyc_wr  = is_mmio && (ofs == CYCLE_OFS) && (dwe == 4'b1111);
    tx_push = is_mmio && (ofs == TXDATA_OFS) && dwe[0];
    st_clr  = is_mmio && (ofs == STATUS_OFS) && dwe[0] && dwdata[ST_OVF_BIT];
  end

  // Overflow set wins over a same-cycle clear.
  always_comb begin
    cycle_d = cyc_wr ? dwdata : cycle_q + 32'd1;
    ovf_d   = ovf_q;
    if (st_clr) begin
      ovf_d = 1'b0;
    end
    if (tx_push && fifo_full && !con_pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      ovf_q   <= ovf_d;
    end
  end

  // RAM survives reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int n = 0; n < 4; n++) begin
        if (dwe[n]) begin
          ram_q[ram_idx][8*n +: 8] <= dwdata[8*n +: 8];
        end
      end
    end
  end

  always_comb begin
    status_word                              = '0;
    status_word[ST_EMPTY_BIT]                = fifo_empty;
    status_word[ST_FULL_BIT]                 = fifo_full;
    status_word[ST_OVF_BIT]                  = ovf_q;
    status_word[ST_COUNT_LSB +: ST_COUNT_W]  = ST_COUNT_W'(fifo_count);
  end

  // Combinational read path so loads complete in the same cycle.
  always_comb begin
    drdata = '0;
    if (!is_mmio) begin
      drdata = ram_q[ram_idx];
    end else begin
      case (ofs)
        CYCLE_OFS:  drdata = cycle_q;
        STATUS_OFS: drdata = status_word;
        default:    drdata = '0;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_con_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (tx_push),
    .push_data  (dwdata[7:0]),
    .pop        (con_pop),
    .head_data  (con_data),
    .head_valid (con_valid),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a console-byte scoreboard.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned DEPTH_WORDS = 1024;
  localparam logic [31:0] CYC_A = 32'h8000_0000 | 32'(CYCLE_OFS);
  localparam logic [31:0] TX_A  = 32'h8000_0000 | 32'(TXDATA_OFS);
  localparam logic [31:0] ST_A  = 32'h8000_0000 | 32'(STATUS_OFS);

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] sb [$];
  logic [31:0] v;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .FIFO_DEPTH  (8),
    .MMIO_BASE   (32'h8000_0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .daddr     (daddr),
    .dwdata    (dwdata),
    .dwe       (dwe),
    .drdata    (drdata),
    .con_data  (con_data),
    .con_valid (con_valid),
    .con_ready (con_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    daddr = a;
    dwe   = 4'b0000;
    #1;
    chk(tag, drdata, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    daddr  = a;
    dwdata = d;
    dwe    = we;
    tick();
    dwe    = 4'b0000;
  endtask

  task automatic tx(input logic [7:0] b, input bit accepted);
    if (accepted) sb.push_back(b);
    wr(TX_A, {24'h0, b}, 4'b0001);
  endtask

  // Console monitor: bytes must match push order and hold while stalled.
  always @(negedge clk) begin
    if (!reset && con_valid) begin
      if (sb.size() == 0) begin
        chk("con_unexpected_valid", 32'(con_valid), 32'd0);
      end else if (con_ready) begin
        chk("con_pop_data", 32'(con_data), 32'(sb[0]));
        void'(sb.pop_front());
      end else begin
        chk("con_hold_data", 32'(con_data), 32'(sb[0]));
      end
    end
  end

  initial begin
    reset = 1'b1; daddr = '0; dwdata = '0; dwe = '0; con_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;

    chk("rst_con_valid", 32'(con_valid), 32'd0);
    chk("rst_con_data", 32'(con_data), 32'd0);
    rd_chk("rst_cycle", CYC_A, 32'd0);
    rd_chk("rst_status", ST_A, 32'h0000_0001);
    for (int i = 1; i <= 3; i++) begin
      tick();
      rd_chk("cycle_inc", CYC_A, 32'(i));
    end

    daddr = CYC_A; dwe = '0; #1; v = drdata;
    wr(CYC_A, 32'h0000_1234, 4'b0011);
    rd_chk("cycle_partial_ignored", CYC_A, v + 32'd1);
    wr(CYC_A, 32'hFFFF_FFFE, 4'b1111);
    rd_chk("cycle_load", CYC_A, 32'hFFFF_FFFE);
    tick();
    rd_chk("cycle_max", CYC_A, 32'hFFFF_FFFF);
    tick();
    rd_chk("cycle_wrap", CYC_A, 32'd0);

    wr(32'h10, 32'h1122_3344, 4'b1111);
    wr(32'h12, 32'h00AA_0000, 4'b0100);
    rd_chk("ram_lane", 32'h10, 32'h11AA_3344);
    rd_chk("ram_alias", 32'h10 + 32'(4 * DEPTH_WORDS), 32'h11AA_3344);
    daddr = 32'h10; dwdata = 32'hDEAD_BEEF; dwe = 4'b1111; #1;
    chk("ram_rdw_old", drdata, 32'h11AA_3344);
    tick(); dwe = '0;
    rd_chk("ram_rdw_new", 32'h10, 32'hDEAD_BEEF);
    rd_chk("txdata_reads0", TX_A, 32'd0);
    rd_chk("unmapped_reads0", 32'h8000_000C, 32'd0);

    con_ready = 1'b0;
    sb.push_back(8'h48);
    daddr = TX_A; dwdata = 32'h48; dwe = 4'b0001; #1;
    chk("push_no_bypass", 32'(con_valid), 32'd0);
    tick(); dwe = '0;
    chk("push_valid", 32'(con_valid), 32'd1);
    tx(8'h69, 1'b1);
    repeat (3) tick();
    rd_chk("status_two", ST_A, 32'h0000_0200);
    con_ready = 1'b1;
    tick(); tick();
    con_ready = 1'b0;
    chk("drain_valid", 32'(con_valid), 32'd0);
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    rd_chk("drain_status", ST_A, 32'h0000_0001);

    tx(8'h41, 1'b1);
    sb.push_back(8'h42);
    con_ready = 1'b1;
    daddr = TX_A; dwdata = 32'h42; dwe = 4'b0001;
    tick(); dwe = '0; con_ready = 1'b0;
    chk("pp_valid", 32'(con_valid), 32'd1);
    chk("pp_data", 32'(con_data), 32'h42);
    rd_chk("pp_status", ST_A, 32'h0000_0100);
    con_ready = 1'b1; tick(); con_ready = 1'b0;
    rd_chk("pp_drain_status", ST_A, 32'h0000_0001);

    for (int i = 0; i < 9; i++) tx(8'h30 + 8'(i), i < 8);
    rd_chk("ovf_status", ST_A, 32'h0000_0806);
    con_ready = 1'b1;
    tx(8'h39, 1'b1);
    con_ready = 1'b0;
    rd_chk("ovf_pushpop_status", ST_A, 32'h0000_0806);
    wr(ST_A, 32'h4, 4'b0001);
    rd_chk("ovf_clear", ST_A, 32'h0000_0802);
    con_ready = 1'b1; repeat (8) tick(); con_ready = 1'b0;
    chk("ovf_drain_sb_empty", 32'(sb.size()), 32'd0);
    rd_chk("ovf_drain_status", ST_A, 32'h0000_0001);

    for (int i = 0; i < 3; i++) tx(8'h61 + 8'(i), 1'b1);
    rd_chk("mid_status", ST_A, 32'h0000_0300);
    reset = 1'b1; tick(); reset = 1'b0;
    sb.delete();
    chk("mr_con_valid", 32'(con_valid), 32'd0);
    chk("mr_con_data", 32'(con_data), 32'd0);
    rd_chk("mr_cycle", CYC_A, 32'd0);
    rd_chk("mr_status", ST_A, 32'h0000_0001);
    rd_chk("mr_ram_kept", 32'h10, 32'hDEAD_BEEF);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-bus responder for the single-cycle RV32I core: it answers the core's `daddr`/`dwdata`/`dwe` requests with `drdata`. It holds a word-addressed RAM with byte-lane writes and a small MMIO window. The window contains a free-running cycle counter and a console TX FIFO, which is drained through a valid/ready stream toward a UART or the testbench. Reads are combinational so the core can complete loads in one cycle; all state changes happen on `clk`.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024 — RAM size in 32-bit words; power of two.
- `FIFO_DEPTH`, 8 — console FIFO entries; power of two, ≥2.
- `MMIO_BASE`, 32'h8000_0000 — `daddr[31]=1` selects MMIO; the low byte selects the register.

Ports:
- `clk` in 1 — clock.
- `reset` in 1 — reset, synchronous, active-high; clock `clk`.
- `daddr` in 32 — byte address from the core.
- `dwdata` in 32 — write data, lane-aligned.
- `dwe` in 4 — byte write enables; bit n writes `dwdata[8n+7:8n]`.
- `drdata` out 32 — read data for the word at `daddr[31:2]`.
- `con_data` out 8 — head byte of the console FIFO.
- `con_valid` out 1 — FIFO is non-empty.
- `con_ready` in 1 — sink accepts `con_data`.

## Operation
- **Decode.**
  - `daddr[31]=0` selects RAM; the index is `daddr[log2(DEPTH_WORDS)+1:2]`.
  - Higher address bits are ignored, so the RAM aliases/wraps.
  - `daddr[1:0]` is ignored for indexing.
- **RAM read.** `drdata` is the full aligned word, combinational. Lane extraction and sign extension are done by the core.
- **RAM write.** At posedge, each lane with `dwe[n]=1` is written. Reset does not clear RAM.
- **MMIO registers** (offset = `daddr[7:0]`):
  - **0x00 CYCLE**
    - 32-bit counter: reset 0, +1 every cycle, wraps 0xFFFF_FFFF→0.
    - A write with `dwe=4'b1111` loads `dwdata`. The value reads back as `dwdata` in the next cycle and increments from there.
    - Partial writes are ignored.
  - **0x04 TXDATA** (write-only; reads 0)
    - A write with `dwe[0]=1` pushes `dwdata[7:0]`.
    - The push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
    - If the push is rejected, the byte is dropped and sticky OVF is set.
  - **0x08 STATUS**
    - bit0 EMPTY, bit1 FULL, bit2 OVF, bits[15:8] occupancy count; all other bits 0.
    - A write with `dwe[0]=1` and `dwdata[2]=1` clears OVF. If an overflow occurs in the same cycle, set wins.
  - Any other MMIO offset reads 0 and ignores writes.
- **Console stream**
  - A pop occurs when `con_valid && con_ready`.
  - `con_data` and `con_valid` are registered FIFO outputs.
  - `con_data` is held stable while `con_valid && !con_ready`.
  - Bytes leave in push order.

## Timing
- **Reset values:**
  - `con_valid`=0, `con_data`=0.
  - FIFO empty, OVF=0, CYCLE=0.
  - STATUS reads 0x0000_0001.
- **Read latency.** Zero cycles, combinational from `daddr`. A read concurrent with a write to the same word returns the old value.
- **Write latency.** Visible to reads one cycle after the posedge.
- **Push latency.** A push into an empty FIFO raises `con_valid` after one edge; there is no same-cycle bypass.
- **Simultaneous push and pop:**
  - Count is unchanged.
  - When full, the push is accepted and OVF is not set.
  - When the FIFO has one entry, `con_valid` stays high and `con_data` advances to the new byte.
- **Pop on empty.** Impossible, since `con_valid`=0.
- **Count width.** `log2(FIFO_DEPTH)+1` bits, zero-extended into bits[15:8].
- **Reset mid-stream.** The FIFO is flushed and `con_valid` drops at the next edge regardless of `con_ready`. RAM contents persist.

## Structure
- Shared package `dmem_pkg`:
  - MMIO offset constants `CYCLE_OFS`, `TXDATA_OFS`, `STATUS_OFS`.
  - STATUS bit indices.
  - `MMIO_BASE` default.
- Sub-module `sync_fifo`:
  - Parameterised width/depth.
  - `push`/`pop`/`full`/`empty`/`count` ports.
  - Registered head output.
- Top level contains the decode, RAM array, counter and OVF logic.

## Test plan
- **Byte-lane write.**
  - Stimulus: SW 0x1122_3344 to 0x10; SB with `dwe=4'b0100`, `dwdata=0x00AA_0000` to 0x12.
  - Required: read 0x10 = 0x11AA_3344. Read 0x10 + 4·DEPTH_WORDS also = 0x11AA_3344 (alias).
- **Cycle counter.**
  - Stimulus: read 0x8000_0000 after reset deasserts; write 0xFFFF_FFFE with `dwe=4'b1111`.
  - Required: reads 0 on the first cycle out of reset, +1 per cycle. After the write, reads 0xFFFF_FFFE, 0xFFFF_FFFF, then 0.
- **Console order.**
  - Stimulus: push 'H','i' with `con_ready`=0 for 3 cycles, then `con_ready`=1.
  - Required: `con_data`='H' held stable while stalled, then 'H','i'; `con_valid` falls after 2 pops; STATUS = 0x1.
- **Overflow.**
  - Stimulus: push 9 bytes with `con_ready`=0.
  - Required: STATUS = 0x0000_0806 (count 8, FULL, OVF).
  - Then a 10th push with `con_ready`=1 in the same cycle is accepted and the count stays 8.
  - Then writing 0x4 to STATUS reads back 0x0806 with OVF cleared = 0x0802.
- **Reset mid-stream.**
  - Stimulus: 3 bytes queued, pulse `reset` for 1 cycle.
  - Required: `con_valid`=0, STATUS=0x1, CYCLE=0. The RAM word written earlier is unchanged.
